// File: rtl/obstacle_gen_if.sv
// Control and geometry bus between obstacle_gen and its consumers: frame tick and
// game mode go in, packed obstacle rectangles and the score come out.
interface obstacle_gen_if;
  logic         tick;
  logic [1:0]   gamemode;
  logic [199:0] obstacle_x;
  logic [179:0] obstacle_y;
  logic [9:0]   score;

  modport master (
    output tick,
    output gamemode,
    input  obstacle_x,
    input  obstacle_y,
    input  score
  );

  modport slave (
    input  tick,
    input  gamemode,
    output obstacle_x,
    output obstacle_y,
    output score
  );
endinterface

// File: rtl/obstacle_gen.sv
// Ten-slot obstacle generator: spawns LFSR-sized obstacles at the right edge, scrolls
// them left on each running frame tick, retires them past x=0 and counts retirements.
module obstacle_gen #(
  parameter int          SCREEN_W       = 640,
  parameter int          OBS_WIDTH      = 40,
  parameter int          SPEED          = 4,
  parameter int          SPAWN_INTERVAL = 90,
  parameter int          UPPER_BOUND    = 20,
  parameter int          OBS_HEIGHT_MIN = 40,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  obstacle_gen_if.slave bus
);

  localparam int NUM_SLOTS = 10;
  localparam int CNT_W     = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

  localparam logic [9:0]       SPEED_V     = 10'(SPEED);
  localparam logic [9:0]       SPAWN_LEFT  = 10'(SCREEN_W);
  localparam logic [9:0]       SPAWN_RIGHT = 10'(SCREEN_W + OBS_WIDTH - 1);
  localparam logic [8:0]       TOP_BASE    = 9'(UPPER_BOUND);
  localparam logic [8:0]       HEIGHT_BASE = 9'(OBS_HEIGHT_MIN);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SPAWN_INTERVAL - 1);
  localparam logic [15:0]      LFSR_MASK   = 16'hB400;

  typedef enum logic [1:0] {
    MODE_INIT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_PAUSE = 2'b10,
    MODE_END   = 2'b11
  } mode_e;

  typedef struct packed {
    logic       valid;
    logic [9:0] left;
    logic [9:0] right;
    logic [8:0] top;
    logic [8:0] bot;
  } slot_t;

  // Empty slots carry the off-screen sentinel in their own registers, so the
  // output buses are plain wiring from state with no valid-based muxing.
  localparam slot_t EMPTY_SLOT = '{
    valid: 1'b0,
    left:  10'h3FF,
    right: 10'h3FF,
    top:   9'h1FF,
    bot:   9'h1FF
  };

  slot_t [NUM_SLOTS-1:0] slot_q, slot_d;
  logic  [15:0]          lfsr_q, lfsr_d;
  logic  [9:0]           score_q, score_d;
  logic  [CNT_W-1:0]     cnt_q, cnt_d;

  logic [3:0]  n_retired;
  logic [10:0] score_sum;
  logic        placed;
  logic [8:0]  spawn_top;
  logic [8:0]  spawn_bot;

  // Geometry for a spawn in this cycle, taken from the current LFSR value.
  assign spawn_top = TOP_BASE + {1'b0, lfsr_q[7:0]};
  assign spawn_bot = spawn_top + HEIGHT_BASE + {3'b000, lfsr_q[13:8]} - 9'd1;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    slot_d    = slot_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    n_retired = '0;
    score_sum = '0;
    placed    = 1'b0;
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    case (mode_e'(bus.gamemode))
      MODE_INIT: begin
        slot_d  = {NUM_SLOTS{EMPTY_SLOT}};
        score_d = '0;
        cnt_d   = '0;
      end

      MODE_RUN: begin
        if (bus.tick) begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_q[k].valid) begin
              if (slot_q[k].right < SPEED_V) begin
                slot_d[k] = EMPTY_SLOT;
                n_retired = n_retired + 4'd1;
              end else begin
                slot_d[k].right = slot_q[k].right - SPEED_V;
                slot_d[k].left  = (slot_q[k].left < SPEED_V) ? 10'd0
                                                             : slot_q[k].left - SPEED_V;
              end
            end
          end

          score_sum = {1'b0, score_q} + {7'd0, n_retired};
          score_d   = score_sum[10] ? 10'h3FF : score_sum[9:0];

          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            // Eligibility uses pre-tick validity: a slot freed this tick stays empty.
            for (int k = 0; k < NUM_SLOTS; k++) begin
              if (!placed && !slot_q[k].valid) begin
                slot_d[k] = '{
                  valid: 1'b1,
                  left:  SPAWN_LEFT,
                  right: SPAWN_RIGHT,
                  top:   spawn_top,
                  bot:   spawn_bot
                };
                placed = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        // Paused or ended: hold everything except the free-running LFSR.
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the slot array is reset like ordinary flops (not left as
      // uninitialised storage) because its contents drive the outputs directly.
      slot_q  <= {NUM_SLOTS{EMPTY_SLOT}};
      lfsr_q  <= LFSR_SEED;
      score_q <= '0;
      cnt_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      lfsr_q  <= lfsr_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [199:0] obs_x;
  logic [179:0] obs_y;

  always_comb begin
    obs_x = '0;
    obs_y = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      obs_x[k*20 +: 10]    = slot_q[k].left;
      obs_x[k*20+10 +: 10] = slot_q[k].right;
      obs_y[k*18 +: 9]     = slot_q[k].top;
      obs_y[k*18+9 +: 9]   = slot_q[k].bot;
    end
  end

  assign bus.obstacle_x = obs_x;
  assign bus.obstacle_y = obs_y;
  assign bus.score      = score_q;

endmodule

// File: tb/tb_obstacle_gen.sv
// Scoreboard bench for obstacle_gen: three parameterisations driven in turn against a
// slot-list reference model; a separate monitor compares every post-tick output.
module tb_obstacle_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [199:0] X_EMPTY = {20{10'h3FF}};

  logic clk;
  logic rst;

  obstacle_gen_if if_def  ();
  obstacle_gen_if if_full ();
  obstacle_gen_if if_sat  ();

  obstacle_gen u_def (
    .clk (clk),
    .rst (rst),
    .bus (if_def)
  );

  obstacle_gen #(.SPAWN_INTERVAL(1), .SPEED(1)) u_full (
    .clk (clk),
    .rst (rst),
    .bus (if_full)
  );

  obstacle_gen #(.SPAWN_INTERVAL(1), .SPEED(32)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (if_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a list of obstacles kept as plain integers.
  int cur = 0;
  int run_ticks = 0;
  bit m_valid [10];
  int m_left  [10];
  int m_right [10];
  int m_top   [10];
  int m_bot   [10];
  int m_score;
  int m_cnt;
  logic [15:0] m_lfsr;

  function automatic int speed_of(input int inst);
    case (inst)
      1:       return 1;
      2:       return 32;
      default: return 4;
    endcase
  endfunction

  function automatic int interval_of(input int inst);
    return (inst == 0) ? 90 : 1;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

  task automatic model_clear();
    for (int k = 0; k < 10; k++) m_valid[k] = 1'b0;
    m_score = 0;
    m_cnt   = 0;
  endtask

  task automatic model_tick();
    bit was_free [10];
    int retired = 0;
    int spd = speed_of(cur);
    for (int k = 0; k < 10; k++) was_free[k] = !m_valid[k];
    for (int k = 0; k < 10; k++) begin
      if (m_valid[k]) begin
        if (m_right[k] < spd) begin
          m_valid[k] = 1'b0;
          retired++;
        end else begin
          m_right[k] -= spd;
          m_left[k] = (m_left[k] < spd) ? 0 : m_left[k] - spd;
        end
      end
    end
    m_score = (m_score + retired > 1023) ? 1023 : m_score + retired;
    if (m_cnt == interval_of(cur) - 1) begin
      m_cnt = 0;
      for (int k = 0; k < 10; k++) begin
        if (was_free[k]) begin
          m_valid[k] = 1'b1;
          m_left[k]  = 640;
          m_right[k] = 679;
          m_top[k]   = 20 + int'(m_lfsr[7:0]);
          m_bot[k]   = m_top[k] + 40 + int'(m_lfsr[13:8]) - 1;
          break;
        end
      end
    end else begin
      m_cnt++;
    end
  endtask

  typedef struct {
    int           inst;
    logic [199:0] x;
    logic [179:0] y;
    logic [9:0]   score;
  } exp_t;

  exp_t sb_q [$];

  function automatic exp_t snapshot(input int inst);
    exp_t e;
    e.inst  = inst;
    e.score = 10'(m_score);
    for (int k = 0; k < 10; k++) begin
      e.x[k*20 +: 10]    = m_valid[k] ? 10'(m_left[k])  : 10'h3FF;
      e.x[k*20+10 +: 10] = m_valid[k] ? 10'(m_right[k]) : 10'h3FF;
      e.y[k*18 +: 9]     = m_valid[k] ? 9'(m_top[k])    : 9'h1FF;
      e.y[k*18+9 +: 9]   = m_valid[k] ? 9'(m_bot[k])    : 9'h1FF;
    end
    return e;
  endfunction

  task automatic drive(input logic [1:0] gm, input bit tk);
    if_def.tick      = (cur == 0) && tk;
    if_def.gamemode  = (cur == 0) ? gm : 2'b00;
    if_full.tick     = (cur == 1) && tk;
    if_full.gamemode = (cur == 1) ? gm : 2'b00;
    if_sat.tick      = (cur == 2) && tk;
    if_sat.gamemode  = (cur == 2) ? gm : 2'b00;
  endtask

  // One clock cycle of stimulus; an expected snapshot is queued for every tick or reset.
  task automatic cycle(input bit r, input logic [1:0] gm, input bit tk);
    @(negedge clk);
    rst = r;
    drive(gm, tk);
    if (r || gm == 2'b00) model_clear();
    else if (gm == 2'b01 && tk) begin
      model_tick();
      run_ticks++;
    end
    if (r || tk) sb_q.push_back(snapshot(cur));
    @(posedge clk);
    #2;
  endtask

  task automatic random_cycles(input int n, input int tick_pct);
    for (int i = 0; i < n; i++) begin
      int p = $urandom_range(0, 999);
      logic [1:0] gm = (p < 850) ? 2'b01 : (p < 920) ? 2'b10 : (p < 997) ? 2'b11 : 2'b00;
      bit r = ($urandom_range(0, 399) == 0);
      cycle(r, gm, $urandom_range(0, 99) < tick_pct);
    end
  endtask

  // Monitor: whenever the DUT has sampled a tick or reset, compare against the queue.
  initial begin
    exp_t e;
    logic [199:0] ax;
    logic [179:0] ay;
    logic [9:0]   as;
    forever begin
      @(posedge clk);
      if (rst || if_def.tick || if_full.tick || if_sat.tick) begin
        #1;
        check("sb_pending", 200'(sb_q.size() != 0), 200'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          case (e.inst)
            1:       begin ax = if_full.obstacle_x; ay = if_full.obstacle_y; as = if_full.score; end
            2:       begin ax = if_sat.obstacle_x;  ay = if_sat.obstacle_y;  as = if_sat.score;  end
            default: begin ax = if_def.obstacle_x;  ay = if_def.obstacle_y;  as = if_def.score;  end
          endcase
          check("sb_obstacle_x", ax, e.x);
          check("sb_obstacle_y", 200'(ay), 200'(e.y));
          check("sb_score", 200'(as), 200'(e.score));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    drive(2'b00, 1'b0);

    // Default parameters: reset with a concurrent tick, first spawn, pause/end, retirement.
    cur = 0;
    cycle(1'b1, 2'b01, 1'b1);
    run_ticks = 0;
    while (run_ticks < 89) begin
      cycle(1'b0, 2'b01, 1'b1);
      cycle(1'b0, 2'b01, 1'b0);
    end
    check("no_spawn_before_90", if_def.obstacle_x, X_EMPTY);
    cycle(1'b0, 2'b01, 1'b1);
    check("spawn_left",  200'(if_def.obstacle_x[9:0]),   200'(640));
    check("spawn_right", 200'(if_def.obstacle_x[19:10]), 200'(679));
    check("slot1_empty", 200'(if_def.obstacle_x[39:20]), 200'({2{10'h3FF}}));
    cycle(1'b0, 2'b01, 1'b1);
    check("move_left",  200'(if_def.obstacle_x[9:0]),   200'(636));
    check("move_right", 200'(if_def.obstacle_x[19:10]), 200'(675));
    repeat (20) cycle(1'b0, 2'b10, 1'b1);
    check("paused_left", 200'(if_def.obstacle_x[9:0]), 200'(636));
    repeat (20) cycle(1'b0, 2'b11, 1'b1);
    check("ended_left", 200'(if_def.obstacle_x[9:0]), 200'(636));
    cycle(1'b0, 2'b01, 1'b1);
    check("resume_left", 200'(if_def.obstacle_x[9:0]), 200'(632));
    while (run_ticks < 259) cycle(1'b0, 2'b01, 1'b1);
    check("clamp_left",  200'(if_def.obstacle_x[9:0]),   200'(0));
    check("last_right",  200'(if_def.obstacle_x[19:10]), 200'(3));
    cycle(1'b0, 2'b01, 1'b1);
    check("retired_slot0", 200'(if_def.obstacle_x[19:0]), 200'({2{10'h3FF}}));
    check("score_one", 200'(if_def.score), 200'(1));
    cycle(1'b0, 2'b00, 1'b1);
    check("mode00_clear_x", if_def.obstacle_x, X_EMPTY);
    check("mode00_score", 200'(if_def.score), 200'(0));
    random_cycles(900, 75);

    // Spawn every tick, one pixel per tick: fill all ten slots, then drop a spawn.
    cur = 1;
    cycle(1'b1, 2'b01, 1'b0);
    repeat (10) cycle(1'b0, 2'b01, 1'b1);
    check("full_slot0_left", 200'(if_full.obstacle_x[9:0]),     200'(631));
    check("full_slot9_left", 200'(if_full.obstacle_x[189:180]), 200'(640));
    cycle(1'b0, 2'b01, 1'b1);
    check("drop_slot0_left", 200'(if_full.obstacle_x[9:0]),     200'(630));
    check("drop_slot9_left", 200'(if_full.obstacle_x[189:180]), 200'(639));
    check("drop_score",      200'(if_full.score),               200'(0));
    random_cycles(300, 50);

    // Fast scrolling with spawn every tick: drive the score into saturation.
    cur = 2;
    cycle(1'b1, 2'b01, 1'b0);
    repeat (2800) cycle(1'b0, 2'b01, 1'b1);
    check("score_saturated", 200'(if_sat.score), 200'(1023));

    repeat (3) cycle(1'b0, 2'b01, 1'b0);
    check("sb_drain", 200'(sb_q.size()), 200'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
